// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with load/shift frame tracker
// Optional USR_PARITY_EN adds a registered even-parity output of q.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done,
`ifdef USR_PARITY_EN
  output logic             parity,
`endif
  output logic [CW-1:0]    shift_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOADED   = 2'd1,
    SHIFTING = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] right_nb;
  logic [WIDTH-1:0] left_nb;
  logic [WIDTH-1:0] d_next;
  logic             is_load;
  logic             is_shift;

  assign right_nb = {sin_r, q[WIDTH-1:1]};
  assign left_nb  = {q[WIDTH-2:0], sin_l};
  assign is_load  = (mode == 2'b11);
  assign is_shift = (mode == 2'b01) || (mode == 2'b10);

  // Per-cell 4:1 select built from two levels of 2:1 muxes.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      assign d_next[i] = mode[1] ? (mode[0] ? d_in[i] : left_nb[i])
                                 : (mode[0] ? right_nb[i] : q[i]);
    end
  endgenerate

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q         <= '0;
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_cnt <= '0;
    end else begin
      q    <= d_next;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (is_load) begin
            state     <= LOADED;
            busy      <= 1'b1;
            shift_cnt <= '0;
          end
        end
        LOADED: begin
          if (is_load) begin
            shift_cnt <= '0;
          end else if (is_shift) begin
            state     <= SHIFTING;
            shift_cnt <= CW'(1);
          end
        end
        SHIFTING: begin
          if (is_load) begin
            state     <= LOADED;
            shift_cnt <= '0;
          end else if (is_shift) begin
            if (shift_cnt == LAST_CNT) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              shift_cnt <= '0;
            end else begin
              shift_cnt <= shift_cnt + CW'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          shift_cnt <= '0;
        end
      endcase
    end
  end

`ifdef USR_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) parity <= 1'b0;
    else        parity <= ^d_next;
  end
`endif

endmodule
